// File: rtl/load_use_interlock_pkg.sv
// Shared opcode constants and FSM state type for the pipeline interlock.
package load_use_interlock_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STYPE = 7'b0100011;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear+inc together loads 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/load_use_interlock.sv
// Load-use bubble insertion and Dcache-wait pipeline freeze for the 5-stage core.
module load_use_interlock
    import load_use_interlock_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_EX,
    input  logic [4:0]       rd_EX,
    input  logic             RF_write_EX,
    input  logic [6:0]       opcode_ID,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic             Dcache_req_MEM,
    input  logic             Dcache_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic             wait_timeout,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

    state_e              state_q;
    state_e              state_d;
    logic                timeout_q;
    logic                timeout_d;
    logic                load_use_c;
    logic                mem_wait_c;
    logic                freeze_c;
    logic                flush_c;
    logic                wait_hit_c;
    logic [WAIT_W-1:0]   wait_q;

    // Store data (rs2) of a store is covered by WB->MEM forwarding, so it never needs a bubble.
    assign load_use_c = (opcode_EX == OPC_LOAD) && RF_write_EX && (rd_EX != 5'd0) &&
                        ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                         (rs2_used_ID && (rs2_ID == rd_EX) && (opcode_ID != OPC_STYPE)));

    assign mem_wait_c = Dcache_req_MEM && !Dcache_ready;

    // Next state and Mealy control; outputs forced to reset values while rst_n is low.
    always_comb begin
        state_d  = state_q;
        freeze_c = 1'b0;
        flush_c  = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (mem_wait_c) begin
                        freeze_c = 1'b1;
                        state_d  = MEM_WAIT;
                    end else if (load_use_c) begin
                        flush_c = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    freeze_c = 1'b1;
                    if (Dcache_ready) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // True when this freeze cycle brings wait_ctr up to MAX_WAIT.
    always_comb begin
        wait_hit_c = 1'b0;
        if (state_q == RUN) begin
            wait_hit_c = (MAX_WAIT <= 1);
        end else begin
            wait_hit_c = ((32'(wait_q) + 32'd1) >= MAX_WAIT);
        end
    end

    assign timeout_d = timeout_q || (freeze_c && wait_hit_c);

    // State and sticky timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    // wait_ctr restarts at 1 on freeze entry and counts each MEM_WAIT cycle.
    sat_counter #(.W(WAIT_W)) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == RUN),
        .inc_i (freeze_c),
        .cnt_o (wait_q)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (flush_c),
        .cnt_o (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .inc_i (freeze_c),
        .cnt_o (freeze_cnt)
    );

    assign PC_write     = !(freeze_c || flush_c);
    assign IF_ID_write  = !(freeze_c || flush_c);
    assign ID_EX_flush  = flush_c;
    assign pipe_freeze  = freeze_c;
    assign wait_timeout = timeout_q;

endmodule

// File: tb/tb_load_use_interlock.sv
// Directed scoreboard bench for load_use_interlock (small counters and MAX_WAIT=3).
module tb_load_use_interlock;
    import load_use_interlock_pkg::*;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_WAIT = 3;

    localparam logic [6:0] OP_ALU = 7'b0110011;

    // {PC_write, IF_ID_write, ID_EX_flush, pipe_freeze, wait_timeout}
    localparam logic [4:0] RUN_OK = 5'b11000;
    localparam logic [4:0] RUN_TO = 5'b11001;
    localparam logic [4:0] BUBBLE = 5'b00100;
    localparam logic [4:0] FRZ    = 5'b00010;
    localparam logic [4:0] FRZ_TO = 5'b00011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       opcode_EX;
    logic [4:0]       rd_EX;
    logic             RF_write_EX;
    logic [6:0]       opcode_ID;
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic             rs1_used_ID;
    logic             rs2_used_ID;
    logic             Dcache_req_MEM;
    logic             Dcache_ready;
    logic             PC_write;
    logic             IF_ID_write;
    logic             ID_EX_flush;
    logic             pipe_freeze;
    logic             wait_timeout;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] freeze_cnt;
    logic [4:0]       obs_outs;

    typedef struct {
        string      tag;
        logic [4:0] outs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign obs_outs = {PC_write, IF_ID_write, ID_EX_flush, pipe_freeze, wait_timeout};

    load_use_interlock #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode_EX      (opcode_EX),
        .rd_EX          (rd_EX),
        .RF_write_EX    (RF_write_EX),
        .opcode_ID      (opcode_ID),
        .rs1_ID         (rs1_ID),
        .rs2_ID         (rs2_ID),
        .rs1_used_ID    (rs1_used_ID),
        .rs2_used_ID    (rs2_used_ID),
        .Dcache_req_MEM (Dcache_req_MEM),
        .Dcache_ready   (Dcache_ready),
        .PC_write       (PC_write),
        .IF_ID_write    (IF_ID_write),
        .ID_EX_flush    (ID_EX_flush),
        .pipe_freeze    (pipe_freeze),
        .wait_timeout   (wait_timeout),
        .bubble_cnt     (bubble_cnt),
        .freeze_cnt     (freeze_cnt)
    );

    task automatic check_outs(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: outs got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: count got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push expectation, compare on the falling edge, return just after the next rising edge.
    task automatic cyc(input string tag, input logic [4:0] exp);
        exp_t e;
        e.tag  = tag;
        e.outs = exp;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check_outs(e.tag, obs_outs, e.outs);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        opcode_EX      = OP_ALU;
        rd_EX          = 5'd0;
        RF_write_EX    = 1'b0;
        opcode_ID      = OP_ALU;
        rs1_ID         = 5'd0;
        rs2_ID         = 5'd0;
        rs1_used_ID    = 1'b0;
        rs2_used_ID    = 1'b0;
        Dcache_req_MEM = 1'b0;
        Dcache_ready   = 1'b0;
    endtask

    task automatic ex_load(input logic [4:0] rd);
        opcode_EX   = OPC_LOAD;
        rd_EX       = rd;
        RF_write_EX = 1'b1;
    endtask

    task automatic id_instr(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                            input logic u1, input logic u2);
        opcode_ID   = op;
        rs1_ID      = r1;
        rs2_ID      = r2;
        rs1_used_ID = u1;
        rs2_used_ID = u2;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        check_outs("reset_outs", obs_outs, RUN_OK);
        check_cnt("reset_bubble_cnt", bubble_cnt, 4'd0);
        check_cnt("reset_freeze_cnt", freeze_cnt, 4'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use through rs1.
        ex_load(5'd5);
        id_instr(OP_ALU, 5'd5, 5'd1, 1'b1, 1'b1);
        cyc("t1_lu_rs1", BUBBLE);
        idle();
        cyc("t1_after", RUN_OK);
        check_cnt("t1_bubble_cnt", bubble_cnt, 4'd1);

        // Store dependencies and non-hazard cases.
        ex_load(5'd5);
        id_instr(OPC_STYPE, 5'd2, 5'd5, 1'b1, 1'b1);
        cyc("t2_sw_rs2_only", RUN_OK);
        check_cnt("t2_bubble_sw_rs2", bubble_cnt, 4'd1);
        id_instr(OPC_STYPE, 5'd5, 5'd7, 1'b1, 1'b1);
        cyc("t2_sw_rs1", BUBBLE);
        check_cnt("t2_bubble_sw_rs1", bubble_cnt, 4'd2);
        id_instr(OP_ALU, 5'd1, 5'd5, 1'b1, 1'b1);
        cyc("t2_add_rs2", BUBBLE);
        check_cnt("t2_bubble_add_rs2", bubble_cnt, 4'd3);
        id_instr(OP_ALU, 5'd1, 5'd5, 1'b1, 1'b0);
        cyc("t2_rs2_unused", RUN_OK);
        RF_write_EX = 1'b0;
        id_instr(OP_ALU, 5'd5, 5'd1, 1'b1, 1'b1);
        cyc("t2_no_rfwrite", RUN_OK);
        opcode_EX   = OP_ALU;
        RF_write_EX = 1'b1;
        cyc("t2_not_load", RUN_OK);

        // Load to x0 never interlocks.
        ex_load(5'd0);
        id_instr(OP_ALU, 5'd0, 5'd0, 1'b1, 1'b1);
        cyc("t3_x0", RUN_OK);
        check_cnt("t3_bubble_cnt", bubble_cnt, 4'd3);

        // Dcache wait: 4 cycles not ready, then ready; timeout at the third MEM_WAIT cycle.
        idle();
        Dcache_req_MEM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("t4_wait%0d", i), (i < 3) ? FRZ : FRZ_TO);
        end
        Dcache_ready = 1'b1;
        cyc("t4_ready", FRZ_TO);
        idle();
        cyc("t4_back_run", RUN_TO);
        check_cnt("t4_freeze_cnt", freeze_cnt, 4'd5);

        // Reset clears counters and sticky timeout.
        rst_n = 1'b0;
        #1;
        check_outs("rst1_outs", obs_outs, RUN_OK);
        check_cnt("rst1_freeze_cnt", freeze_cnt, 4'd0);
        check_cnt("rst1_bubble_cnt", bubble_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Freeze and load-use together: bubble deferred until back in RUN.
        ex_load(5'd5);
        id_instr(OP_ALU, 5'd5, 5'd1, 1'b1, 1'b0);
        Dcache_req_MEM = 1'b1;
        Dcache_ready   = 1'b0;
        cyc("t5_frz1", FRZ);
        Dcache_ready = 1'b1;
        cyc("t5_frz2", FRZ);
        Dcache_req_MEM = 1'b0;
        Dcache_ready   = 1'b0;
        cyc("t5_deferred_bubble", BUBBLE);
        idle();
        cyc("t5_after", RUN_OK);
        check_cnt("t5_bubble_cnt", bubble_cnt, 4'd1);
        check_cnt("t5_freeze_cnt", freeze_cnt, 4'd2);

        // Long freeze: sticky timeout and freeze_cnt saturation.
        Dcache_req_MEM = 1'b1;
        Dcache_ready   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("t6_wait%0d", i), (i < 3) ? FRZ : FRZ_TO);
        end
        check_cnt("t6_freeze_sat", freeze_cnt, 4'hF);

        // Asynchronous reset in the middle of the freeze.
        rst_n = 1'b0;
        #1;
        check_outs("t6_rst_outs", obs_outs, RUN_OK);
        check_cnt("t6_rst_freeze_cnt", freeze_cnt, 4'd0);
        check_cnt("t6_rst_bubble_cnt", bubble_cnt, 4'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("t6_after_reset", RUN_OK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
